// File: rtl/csr_axil_slave.sv
// csr_axil_slave
// AXI4-Lite responder for the accelerator control/status register file.
//
// Register map (word index = byte address[LOG2_CSR_REG_NUM+1:2]):
//   0 CTRL   : writing 1 to bit0 fires start_pulse; nothing is stored, reads 0
//   1 STATUS : bit0 = sticky done flag, set by done_in, write-1-to-clear
//   2..N-1   : plain read/write registers with per-byte WSTRB
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*   AXI4-Lite write address / data / response channels
//   S_AXI_AR*/R*      AXI4-Lite read address / data channels
//   csr_flat          all registers, register i on bits [32i+:32]
//   start_pulse       one-cycle launch strobe from a CTRL bit0 write
//   done_in           datapath completion strobe feeding STATUS bit0
module csr_axil_slave #(
  parameter int CSR_REG_NUM      = 32,
  parameter int LOG2_CSR_REG_NUM = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [LOG2_CSR_REG_NUM+1:0]   S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [LOG2_CSR_REG_NUM+1:0]   S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [32*CSR_REG_NUM-1:0]     csr_flat,
  output logic                          start_pulse,
  input  logic                          done_in
);
  localparam int IDXW = LOG2_CSR_REG_NUM;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------- write path ----------------
  w_state_e        w_state_q, w_state_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [IDXW-1:0] aw_idx_q, aw_idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic            wr_commit;
  logic            bit0_set;
  logic            done_q, start_pulse_q;

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    wr_commit = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_done_q && w_done_q) begin
          // Both halves held: commit now, respond from the same edge.
          wr_commit = 1'b1;
          bvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          if (S_AXI_AWVALID && awready_q) begin
            aw_done_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[IDXW+1:2];
          end
          if (S_AXI_WVALID && wready_q) begin
            w_done_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // Each READY is open only while idle and that channel is still empty.
    awready_d = (w_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (w_state_d == W_IDLE) && !w_done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // A 1 written into bit0 (lane 0 enabled) drives both CTRL start and STATUS W1C.
  assign bit0_set = wr_commit && wstrb_q[0] && wdata_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q        <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      // done_in outranks a coincident clear so a completion is never lost.
      done_q        <= done_in | (done_q & ~(bit0_set && aw_idx_q == IDXW'(1)));
      start_pulse_q <= bit0_set && aw_idx_q == IDXW'(0);
    end
  end

  // ---------------- register file ----------------
  logic [31:0] csr_view [CSR_REG_NUM];

  for (genvar gi = 0; gi < CSR_REG_NUM; gi++) begin : g_reg
    if (gi == 0) begin : g_ctrl
      assign csr_view[gi] = '0;
    end else if (gi == 1) begin : g_status
      assign csr_view[gi] = {31'b0, done_q};
    end else begin : g_rw
      logic [31:0] reg_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          reg_q <= '0;
        end else if (wr_commit && aw_idx_q == IDXW'(gi)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) reg_q[8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
      assign csr_view[gi] = reg_q;
    end
    assign csr_flat[32*gi +: 32] = csr_view[gi];
  end

  // ---------------- read path ----------------
  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          // Samples the pre-commit value when a write lands on the same edge.
          rdata_d   = csr_view[S_AXI_ARADDR[IDXW+1:2]];
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign start_pulse   = start_pulse_q;

endmodule

// File: tb/tb_csr_axil_slave.sv
module tb_csr_axil_slave;
  localparam int N = 32;
  localparam int L = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [L+1:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [32*N-1:0] csr_flat;
  logic start_pulse, done_in = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csr_axil_slave #(.CSR_REG_NUM(N), .LOG2_CSR_REG_NUM(L)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .csr_flat(csr_flat), .start_pulse(start_pulse), .done_in(done_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive AW and W together, then complete the B handshake.
  task automatic do_write(input logic [L+1:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_p = 1, w_p = 1, aw_hs, w_hs;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    while ((aw_p || w_p) && n < 20) begin
      aw_hs = aw_p && awready; w_hs = w_p && wready;
      tick();
      if (aw_hs) begin aw_p = 0; awvalid = 0; end
      if (w_hs) begin w_p = 0; wvalid = 0; end
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (!bvalid) begin
      total++; bad++;
      $display("FAIL write_timeout addr=%h got bvalid=%b required=1", a, bvalid);
      awvalid = 0; wvalid = 0;
    end
    bready = 1; tick(); bready = 0;
  endtask

  task automatic do_read(input logic [L+1:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1;
    while (!arready && n < 20) begin tick(); n++; end
    tick(); arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (!rvalid) begin
      total++; bad++;
      $display("FAIL read_timeout addr=%h got rvalid=%b required=1", a, rvalid);
    end
    d = rdata;
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    total++; if (awready !== 1'b0) begin bad++; $display("FAIL rst_awready got=%b required=0", awready); end
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL rst_wready got=%b required=0", wready); end
    total++; if (arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%b required=0", arready); end
    total++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin bad++; $display("FAIL rst_valids got b=%b r=%b required 0 0", bvalid, rvalid); end
    total++; if (rdata !== 32'h0 || start_pulse !== 1'b0) begin bad++; $display("FAIL rst_rdata_start got=%h/%b required 0/0", rdata, start_pulse); end
    total++; if (csr_flat !== '0) begin bad++; $display("FAIL rst_csr_flat got nonzero required=0"); end
    rst = 0;
    total++; if (awready !== 1'b0) begin bad++; $display("FAIL rst_release_early got awready=%b required=0", awready); end
    tick();
    total++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL rst_readies_up got=%b required=111", {awready, wready, arready}); end
    $display("test_reset done");
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    awaddr = 7'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    total++; if ({awready, wready, bvalid} !== 3'b000) begin bad++; $display("FAIL sc_capture got aw/w/b=%b required=000", {awready, wready, bvalid}); end
    tick();
    total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("FAIL sc_bvalid got bvalid=%b bresp=%b required 1 00", bvalid, bresp); end
    total++; if (csr_flat[95:64] !== 32'hDEADBEEF) begin bad++; $display("FAIL sc_flat got=%h required=deadbeef", csr_flat[95:64]); end
    bready = 1; tick(); bready = 0;
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL sc_bdrop got=%b required=0", bvalid); end
    do_read(7'h08, d);
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL sc_read got=%h required=deadbeef", d); end
    $display("test_same_cycle write 0x08 read=%h", d);
  endtask

  task automatic test_w_first();
    int extra = 0;
    do_write(7'h0C, 32'hFFFFFFFF, 4'hF);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    tick(); wvalid = 0;
    tick(); tick();
    total++; if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin bad++; $display("FAIL wf_wait got w/aw/b=%b required=010", {wready, awready, bvalid}); end
    awaddr = 7'h0C; awvalid = 1;
    tick(); awvalid = 0;
    tick();
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL wf_bvalid got=%b required=1", bvalid); end
    total++; if (csr_flat[127:96] !== 32'hFF22FF44) begin bad++; $display("FAIL wf_strb got=%h required=ff22ff44", csr_flat[127:96]); end
    bready = 1; tick(); bready = 0;
    repeat (4) begin if (bvalid) extra++; tick(); end
    total++; if (extra !== 0) begin bad++; $display("FAIL wf_single_b got extra=%0d required=0", extra); end
    $display("test_w_first reg3=%h", csr_flat[127:96]);
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    awaddr = 7'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    total++; if (start_pulse !== 1'b0) begin bad++; $display("FAIL ctrl_early got=%b required=0", start_pulse); end
    tick();
    total++; if (start_pulse !== 1'b1) begin bad++; $display("FAIL ctrl_pulse got=%b required=1", start_pulse); end
    bready = 1; tick(); bready = 0;
    total++; if (start_pulse !== 1'b0) begin bad++; $display("FAIL ctrl_pulse_len got=%b required=0", start_pulse); end
    do_read(7'h00, d);
    total++; if (d !== 32'h0 || csr_flat[31:0] !== 32'h0) begin bad++; $display("FAIL ctrl_read got=%h flat=%h required=0", d, csr_flat[31:0]); end
    $display("test_ctrl read=%h", d);
  endtask

  task automatic test_done();
    logic [31:0] d;
    done_in = 1; tick(); done_in = 0;
    do_read(7'h04, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL done_set got=%h required=1", d); end
    do_write(7'h04, 32'h1, 4'hF);
    do_read(7'h04, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL done_w1c got=%h required=0", d); end
    awaddr = 7'h04; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0; done_in = 1;
    tick(); done_in = 0;
    total++; if (csr_flat[63:32] !== 32'h1) begin bad++; $display("FAIL done_prio_flat got=%h required=1", csr_flat[63:32]); end
    bready = 1; tick(); bready = 0;
    do_read(7'h04, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL done_prio_read got=%h required=1", d); end
    $display("test_done status=%h", d);
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    awaddr = 7'h14; wdata = 32'hA5A5A5A5; wstrb = 4'hF; araddr = 7'h08;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick(); awvalid = 0; wvalid = 0; arvalid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || awready !== 1'b0 || arready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got b=%b r=%b rdata=%h aw=%b ar=%b required 1 1 deadbeef 0 0", i, bvalid, rvalid, rdata, awready, arready);
      end
      tick();
    end
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    total++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin bad++; $display("FAIL bp_release got b=%b r=%b required 0 0", bvalid, rvalid); end
    tick();
    total++; if (awready !== 1'b1 || arready !== 1'b1) begin bad++; $display("FAIL bp_ready got aw=%b ar=%b required 1 1", awready, arready); end
    do_read(7'h14, d);
    total++; if (d !== 32'hA5A5A5A5) begin bad++; $display("FAIL bp_read got=%h required=a5a5a5a5", d); end
    $display("test_backpressure reg5=%h", d);
  endtask

  task automatic test_reset_mid();
    awaddr = 7'h10; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    tick();
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL rm_bvalid got=%b required=1", bvalid); end
    #2 rst = 1; #1;
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL rm_async got bvalid=%b required=0", bvalid); end
    total++; if (csr_flat !== '0) begin bad++; $display("FAIL rm_regs got reg4=%h reg3=%h required 0", csr_flat[159:128], csr_flat[127:96]); end
    tick(); rst = 0;
    total++; if (awready !== 1'b0 || bvalid !== 1'b0) begin bad++; $display("FAIL rm_hold got aw=%b b=%b required 0 0", awready, bvalid); end
    tick();
    total++; if ({awready, wready, arready, bvalid} !== 4'b1110) begin bad++; $display("FAIL rm_readies got=%b required=1110", {awready, wready, arready, bvalid}); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_ctrl();
    test_done();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
